ram_mar_responder: RTL
======================

Name: ram_mar_responder

Overview:
- 16x8 program/data memory with its Memory Address Register (MAR), on the CPU's shared 8-bit bus.
- Responds to the control block's strobes: load MAR, RAM write, RAM output enable.
- Optional program-loader FSM fills the RAM from a byte stream while the CPU is held.

Parameters:
- ADDR_W, 4, MAR/RAM address width (RAM depth = 2**ADDR_W = 16).
- DATA_W, 8, bus and RAM word width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- bus_in  input  DATA_W  current value of the shared bus
- bus_out  output  DATA_W  RAM read data driven toward the bus
- bus_oe  output  1  high when bus_out is to be driven onto the bus
- lm  input  1  control strobe: load MAR from bus_in[ADDR_W-1:0]
- ram_we  input  1  control strobe: write bus_in into RAM[MAR]
- ro  input  1  control strobe: RAM output enable
- prog_mode  input  1  request loader mode
- prog_valid  input  1  prog_data valid
- prog_data  input  DATA_W  byte to load
- prog_ready  output  1  loader accepts a byte this cycle
- prog_done  output  1  all 16 locations loaded
- cpu_hold  output  1  CPU must stall (loader owns the RAM)
- mar_q  output  ADDR_W  current MAR value (debug)

Behaviour:
- Reset (async, rst_n=0): MAR=0, all RAM words=0, loader state=IDLE, load_addr=0. Outputs: bus_out=0, bus_oe=0, prog_ready=0, prog_done=0, cpu_hold=0, mar_q=0.
- Reset mid-load: state returns to IDLE and RAM clears immediately; no partial-write hazard.
- lm=1 at a rising edge: MAR <= bus_in[3:0]. bus_in[7:4] are ignored.
- ram_we=1 at a rising edge: RAM[MAR] <= bus_in, using the MAR value before that edge.
  - lm and ram_we in the same cycle: write goes to the old MAR; MAR updates at the same edge.
- Read path is combinational from MAR and RAM.
  - bus_out = RAM[MAR] when ro=1 and state==IDLE; otherwise 0.
  - bus_oe = ro and (state==IDLE).
  - Read latency: data for a newly loaded MAR appears on bus_out in the cycle after the lm edge.
  - ro with ram_we in the same cycle: bus_out shows the old word; the new word is visible next cycle.
- Loader FSM: IDLE, LOAD, DONE.
  - IDLE: prog_mode=1 -> LOAD with load_addr=0.
  - LOAD: prog_ready=1, cpu_hold=1. Each cycle with prog_valid and prog_ready: RAM[load_addr] <= prog_data, load_addr increments.
    - Write at load_addr=15 -> DONE. load_addr wraps to 0 and does not overflow.
    - prog_mode=0 -> IDLE (abort). Words already written remain; load_addr is reset on the next entry.
    - prog_valid=0 holds state.
  - DONE: prog_done=1, cpu_hold=1, prog_ready=0. prog_mode=0 -> IDLE.
  - While state!=IDLE: lm and ram_we are ignored, bus_oe=0, MAR is unchanged.
- mar_q always reflects the MAR register.

Optional Feature:
- Macro: RAM_PROG_LOADER_EN.
- Defined: loader FSM and prog_* / cpu_hold behaviour exactly as above.
- Undefined:
  - No FSM is built; all ports remain.
  - prog_ready=0, prog_done=0, cpu_hold=0 constantly.
  - prog_mode, prog_valid, prog_data are ignored.
  - The block behaves as if permanently in IDLE.

Test Plan:
- Reset with RAM pre-written: pulse rst_n low mid-cycle -> asynchronously bus_out=0, mar_q=0; then lm with bus_in=0x05 and ro=1 -> bus_out=0x00.
- Write/read: lm with bus_in=0xA3, then ram_we with bus_in=0x5C, then ro=1 -> mar_q=3, bus_out=0x5C, bus_oe=1; ro=0 -> bus_out=0, bus_oe=0.
- Simultaneous events: MAR=2; one cycle with lm=1, ram_we=1, bus_in=0x07 -> RAM[2]=0x07, RAM[7] unchanged, mar_q=7.
- Loader (macro defined): prog_mode=1, stream bytes 0x10..0x1F with a prog_valid gap after byte 5 -> prog_done=1 after the 16th accept; cpu_hold=1 throughout; drop prog_mode, then read MAR=9 -> 0x19.
- Loader abort/ignore: in LOAD after 3 bytes, assert lm/ram_we/ro -> no MAR change, bus_oe=0. Drop prog_mode -> IDLE with RAM[0..2] written and RAM[3] unchanged. Re-enter -> first byte lands at address 0.
- Macro undefined: assert prog_mode and prog_valid with data 0xFF -> prog_ready=0, cpu_hold=0, RAM unchanged, and normal lm/ram_we/ro work.

Source files
------------

// File: rtl/ram_mar_responder_if.sv
// rtl/ram_mar_responder_if.sv - CPU bus, control strobe and loader stream bundle for ram_mar_responder
//
// Purpose: groups every non-clock/reset signal of ram_mar_responder.
//   master modport: the CPU/control side (drives bus_in, strobes, loader stream)
//   slave modport : the RAM/MAR block
// Signals:
//   bus_in     - shared bus value seen by the RAM/MAR
//   bus_out    - RAM read data toward the bus, bus_oe qualifies it
//   lm/ram_we/ro - load MAR, write RAM[MAR], RAM output enable
//   prog_mode/prog_valid/prog_data/prog_ready - loader request and byte stream
//   prog_done  - all locations loaded
//   cpu_hold   - loader owns the RAM
//   mar_q      - current MAR value
interface ram_mar_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              lm;
  logic              ram_we;
  logic              ro;
  logic              prog_mode;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_done;
  logic              cpu_hold;
  logic [ADDR_W-1:0] mar_q;

  modport master (
    output bus_in, lm, ram_we, ro, prog_mode, prog_valid, prog_data,
    input  bus_out, bus_oe, prog_ready, prog_done, cpu_hold, mar_q
  );

  modport slave (
    input  bus_in, lm, ram_we, ro, prog_mode, prog_valid, prog_data,
    output bus_out, bus_oe, prog_ready, prog_done, cpu_hold, mar_q
  );
endinterface

// File: rtl/ram_mar_responder.sv
// rtl/ram_mar_responder.sv - 16x8 RAM with MAR on the shared CPU bus, optional program loader
//
// Purpose: memory address register plus program/data RAM answering the
//   control strobes lm (load MAR), ram_we (write RAM[MAR]) and ro (drive
//   RAM[MAR] onto the bus). Reads are combinational from MAR.
// Optional feature macro: RAM_PROG_LOADER_EN
//   defined   - IDLE/LOAD/DONE loader FSM fills RAM from prog_data while
//               holding the CPU off the RAM
//   undefined - no FSM; prog_ready/prog_done/cpu_hold tied low, prog_* ignored
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset (clears MAR, RAM and loader)
//   bus   - ram_mar_responder_if.slave (bus, strobes, loader stream, mar_q)
module ram_mar_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_mar_responder_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;

  logic              idle;       // CPU owns the RAM
  logic              load_we;    // loader write this cycle
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

`ifdef RAM_PROG_LOADER_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] load_addr_nx;
  logic              ready_c, done_c, hold_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load_addr <= '0;
    end else begin
      state     <= state_nx;
      load_addr <= load_addr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    load_addr_nx = load_addr;
    load_we      = 1'b0;
    ready_c      = 1'b0;
    done_c       = 1'b0;
    hold_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.prog_mode) begin
          state_nx     = S_LOAD;
          load_addr_nx = '0;
        end
      end
      S_LOAD: begin
        ready_c = 1'b1;
        hold_c  = 1'b1;
        // ready is unconditional in LOAD, so a valid byte is always taken,
        // even in the cycle that prog_mode drops
        if (bus.prog_valid) begin
          load_we      = 1'b1;
          load_addr_nx = load_addr + 1'b1;   // wraps naturally after the last word
        end
        if (!bus.prog_mode)
          state_nx = S_IDLE;
        else if (bus.prog_valid && (load_addr == ADDR_W'(DEPTH - 1)))
          state_nx = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        hold_c = 1'b1;
        if (!bus.prog_mode)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign idle           = (state == S_IDLE);
  assign load_data      = bus.prog_data;
  assign bus.prog_ready = ready_c;
  assign bus.prog_done  = done_c;
  assign bus.cpu_hold   = hold_c;
`else
  logic unused_prog;
  assign unused_prog    = ^{bus.prog_mode, bus.prog_valid, bus.prog_data};

  assign idle           = 1'b1;
  assign load_we        = 1'b0;
  assign load_addr      = '0;
  assign load_data      = '0;
  assign bus.prog_ready = 1'b0;
  assign bus.prog_done  = 1'b0;
  assign bus.cpu_hold   = 1'b0;
`endif

  // MAR and RAM share one register process so the async clear covers both.
  // ram_we uses the pre-edge MAR, so lm+ram_we together writes the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (load_we) begin
      mem[load_addr] <= load_data;
    end else if (idle) begin
      if (bus.ram_we)
        mem[mar] <= bus.bus_in;
      if (bus.lm)
        mar <= bus.bus_in[ADDR_W-1:0];
    end
  end

  assign bus.bus_oe  = bus.ro && idle;
  assign bus.bus_out = (bus.ro && idle) ? mem[mar] : '0;
  assign bus.mar_q   = mar;
endmodule
